// File: rtl/cpu_slave_cycle.sv
// CPU-side slave bus-cycle engine: synchronises 68030 strobes, issues one-cycle
// register read/write strobes and terminates each cycle with a 32-bit _DSACK.
module cpu_slave_cycle #(
  parameter int SYNC_STAGES = 2,
  parameter int WAIT_STATES = 1
) (
  input  logic        SCLK,
  input  logic        _RST,
  input  logic        _CS,
  input  logic        _AS,
  input  logic        _DS,
  input  logic        R_W,
  input  logic [4:0]  ADDR,
  input  logic        OWN,
  input  logic [31:0] DATA_IN,
  input  logic [31:0] REG_RDATA,
  output logic [4:0]  REG_ADDR,
  output logic        REG_WR,
  output logic        REG_RD,
  output logic [31:0] WDATA,
  output logic [31:0] DATA_OUT,
  output logic [1:0]  _DSACK,
  output logic        DATA_OE_,
  output logic        _LED_RD,
  output logic        _LED_WR,
  output logic        BUSY,
  output logic [2:0]  STATE_DBG
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_WAIT   = 3'd2,
    S_XFER   = 3'd3,
    S_ACK    = 3'd4
  } state_t;

  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_t state, next_state;
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic cs_s, as_s, ds_s, rw_s;
  logic start;
  logic rw_l;
  logic [2:0] wait_cnt;

  // Strobe synchronisers reset to the negated level so no cycle is seen out of reset.
  always_ff @(posedge SCLK or negedge _RST) begin
    if (!_RST) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= {_CS, _AS, _DS, R_W};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign {cs_s, as_s, ds_s, rw_s} = sync_q[SYNC_STAGES-1];
  assign start = ~cs_s & ~as_s & ~ds_s & ~OWN;

  always_ff @(posedge SCLK or negedge _RST) begin
    if (!_RST) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Only _AS ends a cycle once decoded; _CS and OWN are not looked at again.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_DECODE;
      S_DECODE: begin
        if (as_s)                  next_state = S_IDLE;
        else if (WAIT_STATES == 0) next_state = S_XFER;
        else                       next_state = S_WAIT;
      end
      S_WAIT: begin
        if (as_s)               next_state = S_IDLE;
        else if (wait_cnt == 0) next_state = S_XFER;
      end
      S_XFER:   next_state = S_ACK;
      S_ACK:    if (as_s) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge SCLK or negedge _RST) begin
    if (!_RST) begin
      REG_ADDR <= '0;
      rw_l     <= 1'b0;
      wait_cnt <= '0;
      WDATA    <= '0;
      DATA_OUT <= '0;
      _DSACK   <= 2'b11;
    end else begin
      if (state == S_IDLE && start) begin
        REG_ADDR <= ADDR;
        rw_l     <= rw_s;
      end
      if (state == S_DECODE) begin
        wait_cnt <= WAIT_LOAD;
      end else if (state == S_WAIT && wait_cnt != 0) begin
        wait_cnt <= wait_cnt - 3'd1;
      end
      // Write data is captured on the edge entering XFER so it is valid alongside REG_WR.
      if (next_state == S_XFER && state != S_XFER && !rw_l) begin
        WDATA <= DATA_IN;
      end
      if (state == S_XFER && rw_l) begin
        DATA_OUT <= REG_RDATA;
      end
      _DSACK <= (next_state == S_ACK) ? 2'b00 : 2'b11;
    end
  end

  always_comb begin
    BUSY      = (state != S_IDLE);
    REG_WR    = (state == S_XFER) & ~rw_l;
    REG_RD    = (state == S_XFER) & rw_l;
    DATA_OE_  = ~(BUSY & rw_l);
    _LED_RD   = ~(BUSY & rw_l);
    _LED_WR   = ~(BUSY & ~rw_l);
    STATE_DBG = state;
  end

endmodule

// File: tb/tb_cpu_slave_cycle.sv
// Bench for cpu_slave_cycle: four instances sharing one CPU bus, differing only
// in WAIT_STATES (1, 3, 0, 7); instance 0 feeds the transaction scoreboard.
module tb_cpu_slave_cycle;

  localparam int WS0 = 1;
  localparam int WS1 = 3;
  localparam int WS2 = 0;
  localparam int WS3 = 7;

  logic        sclk;
  logic        rst_n;
  logic        cs_n, as_n, ds_n, r_w, own;
  logic [4:0]  addr;
  logic [31:0] data_in, reg_rdata;

  logic [4:0]  reg_addr [4];
  logic        reg_wr   [4];
  logic        reg_rd   [4];
  logic [31:0] wdata    [4];
  logic [31:0] data_out [4];
  logic [1:0]  dsack    [4];
  logic        data_oe_n[4];
  logic        led_rd_n [4];
  logic        led_wr_n [4];
  logic        busy     [4];
  logic [2:0]  state_dbg[4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    cpu_slave_cycle #(
      .SYNC_STAGES(2),
      .WAIT_STATES((g == 0) ? WS0 : (g == 1) ? WS1 : (g == 2) ? WS2 : WS3)
    ) dut (
      .SCLK(sclk), ._RST(rst_n), ._CS(cs_n), ._AS(as_n), ._DS(ds_n), .R_W(r_w),
      .ADDR(addr), .OWN(own), .DATA_IN(data_in), .REG_RDATA(reg_rdata),
      .REG_ADDR(reg_addr[g]), .REG_WR(reg_wr[g]), .REG_RD(reg_rd[g]),
      .WDATA(wdata[g]), .DATA_OUT(data_out[g]), ._DSACK(dsack[g]),
      .DATA_OE_(data_oe_n[g]), ._LED_RD(led_rd_n[g]), ._LED_WR(led_wr_n[g]),
      .BUSY(busy[g]), .STATE_DBG(state_dbg[g])
    );
  end

  // clock / reset
  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [37:0] exp_q[$];
  bit  rd_pend = 0;
  int  wr_cnt[4];
  int  rd_cnt[4];
  int  busy_at[4], xfer_at[4], ack_at[4];
  int  rel_at;
  logic snap_oe, snap_led_rd, snap_led_wr;
  logic [4:0] snap_addr;

  function automatic int ws_of(input int g);
    return (g == 0) ? WS0 : (g == 1) ? WS1 : (g == 2) ? WS2 : WS3;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock, sampled 1 ns after the edge; scoreboard pops for instance 0.
  task automatic step();
    logic [37:0] e;
    @(posedge sclk);
    #1;
    for (int g = 0; g < 4; g++) begin
      if (reg_wr[g]) wr_cnt[g]++;
      if (reg_rd[g]) rd_cnt[g]++;
    end
    if (reg_wr[0]) begin
      chk("sb_write_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_write", {1'b0, reg_addr[0], wdata[0]}, e);
      end
    end
    if (reg_rd[0]) rd_pend = 1;
    if (rd_pend && dsack[0] == 2'b00) begin
      rd_pend = 0;
      chk("sb_read_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_read", {1'b1, reg_addr[0], data_out[0]}, e);
      end
    end
  endtask

  function automatic bit all_released();
    bit r = 1;
    for (int g = 0; g < 4; g++) if (dsack[g] != 2'b11) r = 0;
    return r;
  endfunction

  // driver: full CPU cycle, held until every instance acks, then _AS released
  task automatic run_cycle(input logic rw, input logic [4:0] a, input logic [31:0] d);
    int n;
    bit all_ack;
    exp_q.push_back({rw, a, d});
    for (int g = 0; g < 4; g++) begin
      busy_at[g] = 0; xfer_at[g] = 0; ack_at[g] = 0;
    end
    r_w = rw; addr = a;
    if (rw) reg_rdata = d; else data_in = d;
    cs_n = 0; as_n = 0; ds_n = 0;
    n = 0; all_ack = 0;
    while (!all_ack && n < 40) begin
      step(); n++;
      all_ack = 1;
      for (int g = 0; g < 4; g++) begin
        if (busy[g] && busy_at[g] == 0) busy_at[g] = n;
        if ((reg_wr[g] || reg_rd[g]) && xfer_at[g] == 0) xfer_at[g] = n;
        if (dsack[g] == 2'b00 && ack_at[g] == 0) begin
          ack_at[g] = n;
          if (g == 0) begin
            snap_oe = data_oe_n[0]; snap_led_rd = led_rd_n[0];
            snap_led_wr = led_wr_n[0]; snap_addr = reg_addr[0];
          end
        end
        if (ack_at[g] == 0) all_ack = 0;
      end
    end
    chk("ack_timeout", all_ack, 1);
    as_n = 1; ds_n = 1; cs_n = 1;
    n = 0;
    while (n < 20 && !all_released()) begin
      step(); n++;
    end
    rel_at = n;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0[4], r0[4];
    bit f_busy, f_strobe, f_ack;
    int n;
    logic [31:0] d;

    for (int g = 0; g < 4; g++) begin wr_cnt[g] = 0; rd_cnt[g] = 0; end
    rst_n = 0; cs_n = 1; as_n = 1; ds_n = 1; r_w = 1; own = 0;
    addr = '0; data_in = '0; reg_rdata = '0;
    step(); step();

    // reset state
    chk("rst_dsack", dsack[0], 2'b11);
    chk("rst_oe", data_oe_n[0], 1);
    chk("rst_leds", {led_rd_n[0], led_wr_n[0]}, 2'b11);
    chk("rst_busy", busy[0], 0);
    chk("rst_strobes", {reg_wr[0], reg_rd[0]}, 2'b00);
    chk("rst_regs", {reg_addr[0], wdata[0], data_out[0]}, 0);
    chk("rst_state", state_dbg[0], 0);
    rst_n = 1;
    step(); step(); step();

    // 1: write 0x6 to index 2 (0xDD0008 >> 2 & 0x1f)
    for (int g = 0; g < 4; g++) w0[g] = wr_cnt[g];
    run_cycle(1'b0, 5'd2, 32'h0000_0006);
    chk("t1_decode_edge", busy_at[0], 3);
    chk("t1_xfer_edge", xfer_at[0], 5);
    chk("t1_ack_edge", ack_at[0], 6);
    chk("t1_release_edges", rel_at, 3);
    chk("t1_wr_pulses", wr_cnt[0] - w0[0], 1);
    chk("t1_reg_addr", snap_addr, 5'd2);
    chk("t1_wdata", wdata[0], 32'h6);
    chk("t1_led_wr", snap_led_wr, 0);
    chk("t1_oe_write", snap_oe, 1);
    chk("t1_idle_after", {busy[0], dsack[0], led_wr_n[0]}, 4'b0111);

    // 2: read index 2 returning 0x6
    for (int g = 0; g < 4; g++) r0[g] = rd_cnt[g];
    run_cycle(1'b1, 5'd2, 32'h0000_0006);
    chk("t2_rd_pulses", rd_cnt[0] - r0[0], 1);
    chk("t2_ack_edge", ack_at[0], 6);
    chk("t2_oe_read", snap_oe, 0);
    chk("t2_led_rd", {snap_led_rd, snap_led_wr}, 2'b01);
    chk("t2_release", {data_oe_n[0], led_rd_n[0], dsack[0]}, 4'b1111);
    chk("t2_data_out_held", data_out[0], 32'h6);

    // 3: strobes without chip select
    f_busy = 0; f_strobe = 0; f_ack = 0;
    cs_n = 1; addr = 5'h1f; as_n = 0; ds_n = 0; r_w = 0;
    repeat (10) begin
      step();
      for (int g = 0; g < 4; g++) begin
        if (busy[g]) f_busy = 1;
        if (reg_wr[g] || reg_rd[g]) f_strobe = 1;
        if (dsack[g] != 2'b11) f_ack = 1;
      end
    end
    chk("t3_busy", f_busy, 0);
    chk("t3_strobes", f_strobe, 0);
    chk("t3_dsack", f_ack, 0);
    as_n = 1; ds_n = 1;
    step(); step(); step();

    // 4: _AS withdrawn one clock after DECODE
    for (int g = 0; g < 4; g++) w0[g] = wr_cnt[g];
    exp_q.push_back({1'b0, 5'd9, 32'hCAFE_0009});   // WAIT_STATES=1 instance still reaches XFER
    addr = 5'd9; data_in = 32'hCAFE_0009; r_w = 0;
    cs_n = 0; as_n = 0; ds_n = 0;
    f_ack = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 3) chk("t4_decode_busy", busy[1], 1);
    end
    as_n = 1; ds_n = 1;
    repeat (8) begin
      step();
      if (dsack[1] != 2'b11 || dsack[3] != 2'b11) f_ack = 1;
    end
    cs_n = 1;
    chk("t4_abort_no_wr_ws3", wr_cnt[1] - w0[1], 0);
    chk("t4_abort_no_wr_ws7", wr_cnt[3] - w0[3], 0);
    chk("t4_abort_no_dsack", f_ack, 0);
    chk("t4_abort_idle", {busy[1], state_dbg[1]}, 0);
    chk("t4_ws1_completed", wr_cnt[0] - w0[0], 1);

    // 5: OWN blocks new starts, but not a cycle already decoded
    f_busy = 0;
    own = 1; r_w = 1; addr = 5'd3; reg_rdata = 32'hA5A5_0F0F;
    cs_n = 0; as_n = 0; ds_n = 0;
    repeat (10) begin
      step();
      for (int g = 0; g < 4; g++) if (busy[g]) f_busy = 1;
    end
    chk("t5_own_blocked", f_busy, 0);
    r0[0] = rd_cnt[0];
    exp_q.push_back({1'b1, 5'd3, 32'hA5A5_0F0F});
    own = 0; n = 0;
    while (dsack[0] != 2'b00 && n < 20) begin
      step(); n++;
      if (busy[0]) own = 1;
    end
    chk("t5_own_mid_acked", dsack[0], 2'b00);
    chk("t5_own_mid_rd", rd_cnt[0] - r0[0], 1);
    #2 rst_n = 0;
    #1;
    chk("t5_rst_dsack", dsack[0], 2'b11);
    chk("t5_rst_oe", data_oe_n[0], 1);
    chk("t5_rst_state", {busy[0], state_dbg[0]}, 0);
    chk("t5_rst_data_out", data_out[0], 0);
    cs_n = 1; as_n = 1; ds_n = 1; own = 0;
    #1 rst_n = 1;
    step(); step(); step();

    // 6: back-to-back write/read across all wait-state settings
    for (int g = 0; g < 4; g++) begin w0[g] = wr_cnt[g]; r0[g] = rd_cnt[g]; end
    d = $urandom_range(32'h7FFF_FFFF, 1);
    run_cycle(1'b0, 5'd5, d);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("t6_wr_ack_ws%0d", ws_of(g)), ack_at[g], 5 + ws_of(g));
      chk($sformatf("t6_wr_decode_to_xfer_ws%0d", ws_of(g)), xfer_at[g] - busy_at[g], ws_of(g) + 1);
    end
    d = $urandom_range(32'hFFFF_FFFF, 32'h8000_0000);
    run_cycle(1'b1, 5'd5, d);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("t6_rd_ack_ws%0d", ws_of(g)), ack_at[g], 5 + ws_of(g));
      chk($sformatf("t6_strobes_ws%0d", ws_of(g)),
          {8'(wr_cnt[g] - w0[g]), 8'(rd_cnt[g] - r0[g])}, 16'h0101);
      chk($sformatf("t6_data_out_ws%0d", ws_of(g)), data_out[g], d);
    end

    chk("sb_drained", exp_q.size(), 0);
    chk("sb_no_read_pending", rd_pend, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
